wide_obi_bridge: RTL and testbench

WIDE_OBI_BRIDGE -- requirements
Module: wide_obi_bridge

---
 rtl/wide_obi_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_wide_obi_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_obi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wide_obi_bridge                                                 |
// | Purpose  : Splits one cache-line request (MEM_DATA_WIDTH bits) into        |
// |            MEM_DATA_WIDTH/32 OBI word beats and reassembles read data      |
// |            into a single line-wide response.                               |
// | Ports    : clk_i, rst_i            - clock, sync active-high reset         |
// |            mem_req_*               - line request (valid/ready handshake)  |
// |            mem_rsp_*               - line read response (valid/ready)      |
// |            host_req_o/gnt_i/...    - OBI manager port, 32-bit data         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wide_obi_bridge #(
  parameter int          MEM_DATA_WIDTH = 128,
  parameter int          MEM_ADDR_WIDTH = 28,
  parameter int          MEM_TAG_WIDTH  = 8,
  parameter int          PIPELINED      = 1,
  parameter int          SKIP_EMPTY     = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mem_req_valid_i,
  output logic                          mem_req_ready_o,
  input  logic                          mem_req_rw_i,
  input  logic [MEM_DATA_WIDTH/8-1:0]   mem_req_byteen_i,
  input  logic [MEM_ADDR_WIDTH-1:0]     mem_req_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0]     mem_req_data_i,
  input  logic [MEM_TAG_WIDTH-1:0]      mem_req_tag_i,
  output logic                          mem_rsp_valid_o,
  input  logic                          mem_rsp_ready_i,
  output logic [MEM_DATA_WIDTH-1:0]     mem_rsp_data_o,
  output logic [MEM_TAG_WIDTH-1:0]      mem_rsp_tag_o,
  output logic                          host_req_o,
  input  logic                          host_gnt_i,
  output logic [31:0]                   host_addr_o,
  output logic                          host_we_o,
  output logic [3:0]                    host_be_o,
  output logic [31:0]                   host_wdata_o,
  input  logic                          host_rvalid_i,
  input  logic [31:0]                   host_rdata_i
);

  localparam int c_BEATS      = MEM_DATA_WIDTH / 32;
  localparam int c_CW         = $clog2(c_BEATS) + 1;
  localparam int c_LINE_SHIFT = $clog2(MEM_DATA_WIDTH / 8);
  localparam logic [c_CW-1:0] c_BEATS_CNT = c_CW'(c_BEATS);
  localparam logic [c_CW-1:0] c_LIMIT     = (PIPELINED != 0) ? c_BEATS_CNT : c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RSP   = 2'd3
  } state_e;

  state_e                        r_state;
  logic                          r_ready;
  logic                          r_rsp_valid;
  logic                          r_rw;
  logic [MEM_DATA_WIDTH/8-1:0]   r_byteen;
  logic [MEM_ADDR_WIDTH-1:0]     r_addr;
  logic [MEM_DATA_WIDTH-1:0]     r_data;
  logic [MEM_TAG_WIDTH-1:0]      r_tag;
  logic [MEM_DATA_WIDTH-1:0]     r_rdata;
  logic [c_CW-1:0]               r_issue_cnt;
  logic [c_CW-1:0]               r_rcv_cnt;

  logic [3:0]                    w_beat_be;
  logic [31:0]                   w_beat_wdata;
  logic [31:0]                   w_line_addr;
  logic [31:0]                   w_beat_addr;
  logic [c_CW-1:0]               w_outstanding;
  logic                          w_in_flight;
  logic                          w_issuing;
  logic                          w_skip;
  logic                          w_req;
  logic                          w_grant;
  logic                          w_rvalid;
  logic [c_CW-1:0]               w_issue_nxt;
  logic [c_CW-1:0]               w_rcv_nxt;

  // Beat slice selected by compare rather than a variable part-select so the
  // terminal count (issue_cnt == BEATS) never indexes past the line.
  always_comb begin
    w_beat_be    = 4'h0;
    w_beat_wdata = 32'h0;
    for (int b = 0; b < c_BEATS; b++) begin
      if (r_issue_cnt == c_CW'(b)) begin
        w_beat_be    = r_byteen[4*b +: 4];
        w_beat_wdata = r_data[32*b +: 32];
      end
    end
  end

  // Truncating before the shift keeps exactly the bits that survive mod 2^32.
  assign w_line_addr   = 32'(r_addr) << c_LINE_SHIFT;
  assign w_beat_addr   = BASE_ADDR + w_line_addr + (32'(r_issue_cnt) << 2);

  assign w_outstanding = r_issue_cnt - r_rcv_cnt;
  assign w_in_flight   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_issuing     = (r_state == S_ISSUE) && (r_issue_cnt != c_BEATS_CNT);
  assign w_skip        = w_issuing && (SKIP_EMPTY != 0) && r_rw && (w_beat_be == 4'h0);
  assign w_req         = w_issuing && !w_skip && (w_outstanding < c_LIMIT);
  assign w_grant       = w_req && host_gnt_i;
  // Stray rvalids with nothing outstanding (e.g. after an abort) are dropped.
  assign w_rvalid      = host_rvalid_i && w_in_flight && (w_outstanding != '0);

  // A skipped beat counts as both issued and received in the same cycle.
  assign w_issue_nxt   = r_issue_cnt + c_CW'(w_grant) + c_CW'(w_skip);
  assign w_rcv_nxt     = r_rcv_cnt + c_CW'(w_rvalid) + c_CW'(w_skip);

  // Host outputs are zero whenever no request is presented; while stalled
  // they depend only on registers, so they stay stable until the grant.
  assign host_req_o      = w_req;
  assign host_addr_o     = w_req ? w_beat_addr : 32'h0;
  assign host_we_o       = w_req && r_rw;
  assign host_be_o       = w_req ? (r_rw ? w_beat_be : 4'hF) : 4'h0;
  assign host_wdata_o    = (w_req && r_rw) ? w_beat_wdata : 32'h0;

  assign mem_req_ready_o = r_ready;
  assign mem_rsp_valid_o = r_rsp_valid;
  assign mem_rsp_data_o  = r_rdata;
  assign mem_rsp_tag_o   = r_tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rw        <= 1'b0;
      r_byteen    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_rdata     <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
    end else begin
      if (w_in_flight) begin
        r_issue_cnt <= w_issue_nxt;
        r_rcv_cnt   <= w_rcv_nxt;
        // OBI returns in order, so the receive count is the beat slot.
        if (w_rvalid && !r_rw) begin
          for (int b = 0; b < c_BEATS; b++) begin
            if (r_rcv_cnt == c_CW'(b)) begin
              r_rdata[32*b +: 32] <= host_rdata_i;
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          // Ready rises one cycle after reset release and stays up in IDLE.
          r_ready <= 1'b1;
          if (mem_req_valid_i && r_ready) begin
            r_rw        <= mem_req_rw_i;
            r_byteen    <= mem_req_byteen_i;
            r_addr      <= mem_req_addr_i;
            r_data      <= mem_req_data_i;
            r_tag       <= mem_req_tag_i;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_ready     <= 1'b0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue_nxt == c_BEATS_CNT) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_rcv_nxt == c_BEATS_CNT) begin
            if (r_rw) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RSP;
            end
          end
        end
        S_RSP: begin
          if (mem_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_obi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wide_obi_bridge                                              |
// | Purpose  : Directed self-checking bench for wide_obi_bridge. Two DUTs:     |
// |            u_dut (pipelined, base 0) and u_dut_np (one outstanding beat,   |
// |            base 0x1000_0000). Each has a simple OBI subordinate model that |
// |            returns rdata = 0xA0 + word index within the line.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wide_obi_bridge;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int TW = 8;
  localparam int BW = DW / 8;
  localparam logic [DW-1:0] RD_LINE = 128'h000000A3_000000A2_000000A1_000000A0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_rw;
  logic [BW-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;

  logic          m_valid, m_ready, m_rsp_valid, m_rsp_ready;
  logic [DW-1:0] m_rsp_data;
  logic [TW-1:0] m_rsp_tag;
  logic          m_hreq, m_gnt, m_we, m_rvalid;
  logic [31:0]   m_haddr, m_wdata, m_rdata;
  logic [3:0]    m_be;

  logic          n_valid, n_ready, n_rsp_valid, n_rsp_ready;
  logic [DW-1:0] n_rsp_data;
  logic [TW-1:0] n_rsp_tag;
  logic          n_hreq, n_gnt, n_we, n_rvalid;
  logic [31:0]   n_haddr, n_wdata, n_rdata;
  logic [3:0]    n_be;

  wide_obi_bridge #(
    .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MEM_TAG_WIDTH(TW),
    .PIPELINED(1), .SKIP_EMPTY(1), .BASE_ADDR(32'h0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_valid_i(m_valid), .mem_req_ready_o(m_ready), .mem_req_rw_i(req_rw),
    .mem_req_byteen_i(req_be), .mem_req_addr_i(req_addr), .mem_req_data_i(req_data),
    .mem_req_tag_i(req_tag), .mem_rsp_valid_o(m_rsp_valid), .mem_rsp_ready_i(m_rsp_ready),
    .mem_rsp_data_o(m_rsp_data), .mem_rsp_tag_o(m_rsp_tag),
    .host_req_o(m_hreq), .host_gnt_i(m_gnt), .host_addr_o(m_haddr), .host_we_o(m_we),
    .host_be_o(m_be), .host_wdata_o(m_wdata), .host_rvalid_i(m_rvalid), .host_rdata_i(m_rdata)
  );

  wide_obi_bridge #(
    .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MEM_TAG_WIDTH(TW),
    .PIPELINED(0), .SKIP_EMPTY(1), .BASE_ADDR(32'h1000_0000)
  ) u_dut_np (
    .clk_i(clk), .rst_i(rst),
    .mem_req_valid_i(n_valid), .mem_req_ready_o(n_ready), .mem_req_rw_i(req_rw),
    .mem_req_byteen_i(req_be), .mem_req_addr_i(req_addr), .mem_req_data_i(req_data),
    .mem_req_tag_i(req_tag), .mem_rsp_valid_o(n_rsp_valid), .mem_rsp_ready_i(n_rsp_ready),
    .mem_rsp_data_o(n_rsp_data), .mem_rsp_tag_o(n_rsp_tag),
    .host_req_o(n_hreq), .host_gnt_i(n_gnt), .host_addr_o(n_haddr), .host_we_o(n_we),
    .host_be_o(n_be), .host_wdata_o(n_wdata), .host_rvalid_i(n_rvalid), .host_rdata_i(n_rdata)
  );

  // Subordinate models: rvalid m_lat cycles after each grant (n side: 1 cycle).
  int          m_lat = 1;
  logic [7:0]  m_rv_pipe = 8'h0;
  logic [31:0] m_rd_pipe [8] = '{default: 32'h0};
  assign m_rvalid = m_rv_pipe[0];
  assign m_rdata  = m_rd_pipe[0];

  always @(posedge clk) begin : p_m_sub
    logic [7:0]  v;
    logic [31:0] d [8];
    v = m_rv_pipe >> 1;
    for (int i = 0; i < 7; i++) d[i] = m_rd_pipe[i+1];
    d[7] = 32'h0;
    if (m_hreq && m_gnt) begin
      v[m_lat-1] = 1'b1;
      d[m_lat-1] = 32'hA0 + 32'(m_haddr[3:2]);
    end
    m_rv_pipe <= v;
    m_rd_pipe <= d;
  end

  logic        n_rv_q = 1'b0;
  logic [31:0] n_rd_q = 32'h0;
  assign n_rvalid = n_rv_q;
  assign n_rdata  = n_rd_q;

  always @(posedge clk) begin : p_n_sub
    n_rv_q <= n_hreq && n_gnt;
    n_rd_q <= 32'hA0 + 32'(n_haddr[3:2]);
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : p_main
    int          nreq;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, rsp_seen, rdy_seen;

    rst = 1'b1; m_valid = 1'b0; n_valid = 1'b0; m_gnt = 1'b1; n_gnt = 1'b1;
    m_rsp_ready = 1'b0; n_rsp_ready = 1'b0;
    req_rw = 1'b0; req_be = '0; req_addr = '0; req_data = '0; req_tag = '0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", m_ready, 0);
    chk("rst_hreq", m_hreq, 0);
    chk("rst_rsp_valid", m_rsp_valid, 0);
    chk("rst_host_outs", {m_haddr, m_be, m_we, m_wdata}, 0);
    chk("rst_rsp_data", m_rsp_data, 0);
    chk("rst_rsp_tag", m_rsp_tag, 0);
    chk("np_rst_outs", {n_haddr, n_be, n_we, n_wdata, n_ready, n_rsp_valid, n_hreq}, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", m_ready, 1);

    // Pipelined read, gnt tied high, rvalid one cycle after each grant
    req_rw = 1'b0; req_addr = 28'h10; req_tag = 8'h5A; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    chk("rd_ready_low", m_ready, 0);
    for (int b = 0; b < 4; b++) begin
      chk("rd_hreq", m_hreq, 1);
      chk("rd_addr", m_haddr, 32'h100 + 32'(4*b));
      chk("rd_be_we", {m_be, m_we}, 5'b11110);
      step();
    end
    chk("rd_drain_noreq", m_hreq, 0);
    step();
    chk("rd_rsp_valid", m_rsp_valid, 1);
    chk("rd_rsp_data", m_rsp_data, RD_LINE);
    chk("rd_rsp_tag", m_rsp_tag, 8'h5A);
    m_rsp_ready = 1'b1;
    step();
    m_rsp_ready = 1'b0;
    chk("rd_rsp_done", {m_rsp_valid, m_ready}, 2'b01);

    // Grant stall for 3 cycles, then response back-pressure for 5 cycles
    req_addr = 28'h20; req_tag = 8'h33; m_gnt = 1'b0; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hreq", m_hreq, 1);
      chk("stall_addr", m_haddr, 32'h200);
      chk("stall_be_we_wdata", {m_be, m_we, m_wdata}, {4'hF, 1'b0, 32'h0});
      step();
    end
    m_gnt = 1'b1;
    for (int k = 0; k < 20 && m_rsp_valid !== 1'b1; k++) step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", m_rsp_valid, 1);
      chk("bp_rsp_data", m_rsp_data, RD_LINE);
      chk("bp_rsp_tag", m_rsp_tag, 8'h33);
      step();
    end
    m_rsp_ready = 1'b1;
    step();
    m_rsp_ready = 1'b0;
    chk("bp_rsp_done", {m_rsp_valid, m_ready}, 2'b01);

    // Write with only beat 1 enabled: one OBI beat, no response
    req_rw = 1'b1; req_addr = 28'h30; req_be = 16'h00F0; req_tag = 8'h77;
    req_data = 128'h44444444_33333333_22222222_11111111; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    nreq = 0; rsp_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_hreq) begin
        nreq++; cap_addr = m_haddr; cap_be = m_be; cap_we = m_we; cap_wdata = m_wdata;
      end
      if (m_rsp_valid) rsp_seen = 1'b1;
      step();
    end
    chk("wr_nbeats", nreq, 1);
    chk("wr_addr", cap_addr, 32'h304);
    chk("wr_be_we", {cap_be, cap_we}, 5'b11111);
    chk("wr_wdata", cap_wdata, 32'h22222222);
    chk("wr_no_rsp", rsp_seen, 0);
    chk("wr_ready_back", m_ready, 1);

    // All-empty write: no bus traffic, ready back within BEATS+2 cycles
    req_be = '0; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    nreq = 0; rdy_seen = 1'b0; rsp_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (m_hreq) nreq++;
      if (m_ready) rdy_seen = 1'b1;
      if (m_rsp_valid) rsp_seen = 1'b1;
      step();
    end
    chk("empty_wr_nreq", nreq, 0);
    chk("empty_wr_ready", rdy_seen, 1);
    chk("empty_wr_no_rsp", rsp_seen, 0);

    // Reset in DRAIN with rvalids still pending (4-cycle read latency)
    m_lat = 4; req_rw = 1'b0; req_addr = 28'h40; req_tag = 8'hC3; m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    repeat (4) step();
    chk("abort_in_drain", m_hreq, 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("abort_ctrl", {m_ready, m_hreq, m_rsp_valid, m_we}, 4'b0000);
    chk("abort_host_outs", {m_haddr, m_be, m_wdata}, 0);
    chk("abort_rsp_data", m_rsp_data, 0);
    chk("abort_rsp_tag", m_rsp_tag, 0);
    rst = 1'b0;
    m_lat = 1;
    rsp_seen = 1'b0; nreq = 0;
    for (int k = 0; k < 8; k++) begin
      if (m_rsp_valid) rsp_seen = 1'b1;
      if (m_hreq) nreq++;
      step();
    end
    chk("abort_late_rvalid_no_rsp", rsp_seen, 0);
    chk("abort_no_req", nreq, 0);
    chk("abort_ready", m_ready, 1);

    // Non-pipelined read: next request only after each rvalid
    req_rw = 1'b0; req_addr = 28'h10; req_tag = 8'h9C; n_valid = 1'b1;
    step();
    n_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("np_hreq", n_hreq, (k % 2 == 0));
      if (k % 2 == 0) chk("np_addr", n_haddr, 32'h1000_0100 + 32'(2*k));
      step();
    end
    chk("np_rsp_valid", n_rsp_valid, 1);
    chk("np_rsp_data", n_rsp_data, RD_LINE);
    chk("np_rsp_tag", n_rsp_tag, 8'h9C);
    n_rsp_ready = 1'b1;
    step();
    n_rsp_ready = 1'b0;

    // Address wrap: (0xFFFFFFF*16 + 0x10000000) mod 2^32
    req_addr = 28'hFFF_FFFF; req_tag = 8'h11; n_valid = 1'b1;
    step();
    n_valid = 1'b0;
    chk("wrap_addr0", n_haddr, 32'h0FFF_FFF0);
    repeat (2) step();
    chk("wrap_addr1", n_haddr, 32'h0FFF_FFF4);
    for (int k = 0; k < 20 && n_rsp_valid !== 1'b1; k++) step();
    chk("wrap_rsp_valid", n_rsp_valid, 1);
    chk("wrap_rsp_data", n_rsp_data, RD_LINE);
    n_rsp_ready = 1'b1;
    step();
    n_rsp_ready = 1'b0;
    chk("wrap_done", {n_rsp_valid, n_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
